// File: rtl/fwd_hazard_unit.sv
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : EX-stage operand forwarding, load-use / MDU stall generation and
//            a single-entry scoreboard for one in-flight multi-cycle MDU op.
//            Optional perf counters are enabled by defining FWD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_unit #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int MDU_LAT = 4,   // must exceed NUM_FWD
  parameter int SEL_W   = $clog2(NUM_FWD + 2)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr_ex,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr_id,
  input  logic [NUM_SRC-1:0]          src_used_id,
  input  logic                        dst_wr_id,
  input  logic [ADDR_W-1:0]           dst_addr_id,
  input  logic                        mdu_op_id,
  input  logic [NUM_FWD-1:0]          stg_wr,
  input  logic [NUM_FWD*ADDR_W-1:0]   stg_addr,
  input  logic                        load_ex,
  input  logic [ADDR_W-1:0]           load_addr_ex,
  input  logic                        mdu_start,
  input  logic [ADDR_W-1:0]           mdu_dst,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall_id,
  output logic                        mdu_busy,
  output logic                        mdu_wb,
  output logic [ADDR_W-1:0]           mdu_wb_addr,
  output logic                        mdu_err,
  output logic [31:0]                 stall_cnt,
  output logic [31:0]                 fwd_cnt
);

  localparam int                CNT_W    = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MDU_LAT - 1);
  localparam logic [SEL_W-1:0]  SEL_MDU  = SEL_W'(NUM_FWD + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  pend_q, pend_d;
  logic               err_q, err_d;
  logic               wb_now;

  // ---------------------------------------------------------------- MDU FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    err_d   = err_q;
    wb_now  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mdu_start) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_INIT;
          pend_d  = mdu_dst;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          wb_now = 1'b1;
          // Back-to-back issue is legal in the write-back cycle.
          if (mdu_start) begin
            cnt_d  = CNT_INIT;
            pend_d = mdu_dst;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (mdu_start) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign mdu_busy    = (state_q == ST_BUSY);
  assign mdu_wb      = wb_now;
  assign mdu_wb_addr = wb_now ? pend_q : '0;
  assign mdu_err     = err_q;

  // ------------------------------------------------------------- forwarding
  generate
    for (genvar p = 0; p < NUM_SRC; p++) begin : g_fwd_port
      logic [ADDR_W-1:0] ex_src;
      logic [SEL_W-1:0]  sel;

      assign ex_src = src_addr_ex[p*ADDR_W +: ADDR_W];

      // Scan oldest to youngest so the youngest matching stage overwrites.
      always_comb begin
        sel = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
          if (stg_wr[k] && (stg_addr[k*ADDR_W +: ADDR_W] == ex_src)) begin
            sel = SEL_W'(k + 1);
          end
        end
        if (wb_now && (pend_q == ex_src)) begin
          sel = SEL_MDU;
        end
        if (ex_src == '0) begin
          sel = '0;
        end
      end

      assign fwd_sel[p*SEL_W +: SEL_W] = sel;
    end
  endgenerate

  // ---------------------------------------------------------------- hazards
  logic [NUM_SRC-1:0] load_hit;
  logic [NUM_SRC-1:0] pend_hit;

  generate
    for (genvar p = 0; p < NUM_SRC; p++) begin : g_id_port
      logic [ADDR_W-1:0] id_src;
      assign id_src      = src_addr_id[p*ADDR_W +: ADDR_W];
      assign load_hit[p] = src_used_id[p] && (id_src == load_addr_ex);
      assign pend_hit[p] = src_used_id[p] && (id_src == pend_q);
    end
  endgenerate

  logic load_stall;
  logic mdu_stall;
  logic pend_nz;

  assign pend_nz    = (pend_q != '0);
  assign load_stall = load_ex && (load_addr_ex != '0) && (|load_hit);
  // The dependent instruction is released in the write-back cycle and reads
  // the register file once it reaches EX.
  assign mdu_stall  = mdu_busy && !wb_now &&
                      ((pend_nz && (|pend_hit)) ||
                       (dst_wr_id && pend_nz && (dst_addr_id == pend_q)) ||
                       mdu_op_id);
  assign stall_id   = load_stall || mdu_stall;

  // ----------------------------------------------------------- perf counters
`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic        any_fwd;

  assign any_fwd = |fwd_sel;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_id && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (any_fwd && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Brief    : Directed + randomized bench for fwd_hazard_unit against a
//            cycle-indexed behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_unit;

  localparam int ADDR_W  = 5;
  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 2;
  localparam int MDU_LAT = 4;
  localparam int SEL_W   = $clog2(NUM_FWD + 2);

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_SRC*ADDR_W-1:0]  src_addr_ex;
  logic [NUM_SRC*ADDR_W-1:0]  src_addr_id;
  logic [NUM_SRC-1:0]         src_used_id;
  logic                       dst_wr_id;
  logic [ADDR_W-1:0]          dst_addr_id;
  logic                       mdu_op_id;
  logic [NUM_FWD-1:0]         stg_wr;
  logic [NUM_FWD*ADDR_W-1:0]  stg_addr;
  logic                       load_ex;
  logic [ADDR_W-1:0]          load_addr_ex;
  logic                       mdu_start;
  logic [ADDR_W-1:0]          mdu_dst;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       stall_id;
  logic                       mdu_busy;
  logic                       mdu_wb;
  logic [ADDR_W-1:0]          mdu_wb_addr;
  logic                       mdu_err;
  logic [31:0]                stall_cnt;
  logic [31:0]                fwd_cnt;

  fwd_hazard_unit #(
    .ADDR_W (ADDR_W),
    .NUM_SRC(NUM_SRC),
    .NUM_FWD(NUM_FWD),
    .MDU_LAT(MDU_LAT),
    .SEL_W  (SEL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_addr_ex (src_addr_ex),
    .src_addr_id (src_addr_id),
    .src_used_id (src_used_id),
    .dst_wr_id   (dst_wr_id),
    .dst_addr_id (dst_addr_id),
    .mdu_op_id   (mdu_op_id),
    .stg_wr      (stg_wr),
    .stg_addr    (stg_addr),
    .load_ex     (load_ex),
    .load_addr_ex(load_addr_ex),
    .mdu_start   (mdu_start),
    .mdu_dst     (mdu_dst),
    .fwd_sel     (fwd_sel),
    .stall_id    (stall_id),
    .mdu_busy    (mdu_busy),
    .mdu_wb      (mdu_wb),
    .mdu_wb_addr (mdu_wb_addr),
    .mdu_err     (mdu_err),
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: the MDU op is remembered by the absolute cycle it was issued in.
  int               cyc     = 0;
  bit               m_busy  = 1'b0;
  int               m_start = 0;
  logic [ADDR_W-1:0] m_pend = '0;
  bit               m_err   = 1'b0;
  logic [31:0]      m_stall = '0;
  logic [31:0]      m_fwd   = '0;

  function automatic logic [ADDR_W-1:0] fld(input logic [NUM_SRC*ADDR_W-1:0] v, input int i);
    return v[i*ADDR_W +: ADDR_W];
  endfunction

  task automatic step();
    bit           e_wb, e_stall, e_any_fwd, e_load, e_mdu;
    int           e_sel;
    logic [31:0]  e_sc, e_fc;
    #1;
    e_wb      = m_busy && (cyc == m_start + MDU_LAT);
    e_any_fwd = 1'b0;
    for (int p = 0; p < NUM_SRC; p++) begin
      logic [ADDR_W-1:0] s;
      s = fld(src_addr_ex, p);
      e_sel = 0;
      if (s != 0) begin
        if (e_wb && m_pend == s) e_sel = NUM_FWD + 1;
        else begin
          for (int k = 0; k < NUM_FWD; k++) begin
            if (e_sel == 0 && stg_wr[k] && stg_addr[k*ADDR_W +: ADDR_W] == s) e_sel = k + 1;
          end
        end
      end
      if (e_sel != 0) e_any_fwd = 1'b1;
      if (chk_en) check($sformatf("fwd_sel[%0d]", p), 32'(fwd_sel[p*SEL_W +: SEL_W]), 32'(e_sel));
    end
    e_load = 1'b0;
    e_mdu  = mdu_op_id || (dst_wr_id && m_pend != 0 && dst_addr_id == m_pend);
    for (int p = 0; p < NUM_SRC; p++) begin
      if (src_used_id[p] && load_ex && load_addr_ex != 0 && fld(src_addr_id, p) == load_addr_ex) e_load = 1'b1;
      if (src_used_id[p] && m_pend != 0 && fld(src_addr_id, p) == m_pend) e_mdu = 1'b1;
    end
    e_stall = e_load || (m_busy && !e_wb && e_mdu);
`ifdef FWD_PERF_CNT_EN
    e_sc = m_stall;
    e_fc = m_fwd;
`else
    e_sc = 32'd0;
    e_fc = 32'd0;
`endif
    if (chk_en) begin
      check("stall_id", 32'(stall_id), 32'(e_stall));
      check("mdu_busy", 32'(mdu_busy), 32'(m_busy));
      check("mdu_wb",   32'(mdu_wb),   32'(e_wb));
      if (e_wb) check("mdu_wb_addr", 32'(mdu_wb_addr), 32'(m_pend));
      check("mdu_err",  32'(mdu_err),  32'(m_err));
      check("stall_cnt", stall_cnt, e_sc);
      check("fwd_cnt",   fwd_cnt,   e_fc);
    end
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_pend = '0; m_err = 1'b0; m_stall = '0; m_fwd = '0;
    end else begin
      if (e_stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (e_any_fwd && m_fwd != 32'hFFFF_FFFF) m_fwd = m_fwd + 1;
      if (mdu_start && (!m_busy || e_wb)) begin
        m_busy = 1'b1; m_start = cyc; m_pend = mdu_dst;
      end else if (mdu_start) begin
        m_err = 1'b1;
      end else if (e_wb) begin
        m_busy = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; src_addr_ex = '0; src_addr_id = '0; src_used_id = '0;
    dst_wr_id = 1'b0; dst_addr_id = '0; mdu_op_id = 1'b0; stg_wr = '0;
    stg_addr = '0; load_ex = 1'b0; load_addr_ex = '0; mdu_start = 1'b0; mdu_dst = '0;
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return ADDR_W'(3);
      2: return ADDR_W'(5);
      default: return ADDR_W'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(mdu_busy), 0);
    check("rst_wb",   32'(mdu_wb), 0);
    check("rst_wb_addr", 32'(mdu_wb_addr), 0);
    check("rst_err",  32'(mdu_err), 0);
    check("rst_stall_cnt", stall_cnt, 0);

    // Youngest stage wins; r0 never forwards.
    stg_wr = 2'b11; stg_addr = {5'd8, 5'd8}; src_addr_ex[4:0] = 5'd8;
    #1 check("fwd_prio", 32'(fwd_sel[SEL_W-1:0]), 1);
    step();
    stg_addr[4:0] = 5'd0; src_addr_ex[4:0] = 5'd0;
    #1 check("fwd_r0", 32'(fwd_sel[SEL_W-1:0]), 0);
    step();

    // Load-use on ID port 1, then bubble, then unused port.
    idle_inputs();
    load_ex = 1'b1; load_addr_ex = 5'd3; src_addr_id[9:5] = 5'd3; src_used_id = 2'b10;
    #1 check("load_use", 32'(stall_id), 1);
    step();
    load_ex = 1'b0;
    #1 check("load_bubble", 32'(stall_id), 0);
    step();
    load_ex = 1'b1; src_used_id = 2'b00;
    #1 check("load_unused", 32'(stall_id), 0);
    step();

    // MDU op to r5: stall t+1..t+3, write-back and forward at t+4.
    idle_inputs();
    mdu_start = 1'b1; mdu_dst = 5'd5;
    step();
    mdu_start = 1'b0; src_addr_id[4:0] = 5'd5; src_used_id = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      mdu_start = (i == 2); mdu_dst = 5'd9;
      #1 check("mdu_raw_stall", 32'(stall_id), 1);
      check("mdu_busy_seq", 32'(mdu_busy), 1);
      step();
    end
    mdu_start = 1'b1; mdu_dst = 5'd7; src_addr_ex[4:0] = 5'd5;
    #1 check("mdu_wb_pulse", 32'(mdu_wb), 1);
    check("mdu_wb_r5", 32'(mdu_wb_addr), 5);
    check("mdu_fwd", 32'(fwd_sel[SEL_W-1:0]), NUM_FWD + 1);
    check("mdu_release", 32'(stall_id), 0);
    check("mdu_err_set", 32'(mdu_err), 1);
    step();
    idle_inputs(); dst_wr_id = 1'b1; dst_addr_id = 5'd7;
    #1 check("mdu_waw", 32'(stall_id), 1);
    step();
    dst_wr_id = 1'b0; mdu_op_id = 1'b1;
    #1 check("mdu_struct", 32'(stall_id), 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 check("rst_mid_busy", 32'(mdu_busy), 0);
    check("rst_mid_stall", 32'(stall_id), 0);
    check("rst_mid_err", 32'(mdu_err), 0);
    for (int i = 0; i < 4; i++) step();

    // Exactly three stall cycles after reset.
    rst = 1'b1; step(); rst = 1'b0;
    load_ex = 1'b1; load_addr_ex = 5'd3; src_addr_id[4:0] = 5'd3; src_used_id = 2'b01; mdu_op_id = 1'b0;
    for (int i = 0; i < 3; i++) step();
    idle_inputs();
`ifdef FWD_PERF_CNT_EN
    #1 check("stall_cnt_3", stall_cnt, 3);
`else
    #1 check("stall_cnt_off", stall_cnt, 0);
`endif
    step();

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int p = 0; p < NUM_SRC; p++) begin
        src_addr_ex[p*ADDR_W +: ADDR_W] = rnd_addr();
        src_addr_id[p*ADDR_W +: ADDR_W] = rnd_addr();
      end
      for (int k = 0; k < NUM_FWD; k++) stg_addr[k*ADDR_W +: ADDR_W] = rnd_addr();
      src_used_id  = NUM_SRC'($urandom);
      stg_wr       = NUM_FWD'($urandom);
      dst_wr_id    = 1'($urandom);
      dst_addr_id  = rnd_addr();
      mdu_op_id    = ($urandom_range(0, 3) == 0);
      load_ex      = ($urandom_range(0, 2) == 0);
      load_addr_ex = rnd_addr();
      mdu_start    = ($urandom_range(0, 4) == 0);
      mdu_dst      = rnd_addr();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
